// File: rtl/pcie_us_msix_pkg.sv
// Shared types and widths for the MSI-X interrupt arbiter.
//   state_t    : arbiter FSM state encoding
//   msix_msg_t : address/data payload handed to the PCIe core
package pcie_us_msix_pkg;

  localparam int unsigned MSIX_ADDR_WIDTH = 64;
  localparam int unsigned MSIX_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [MSIX_ADDR_WIDTH-1:0] addr;
    logic [MSIX_DATA_WIDTH-1:0] data;
  } msix_msg_t;

endpackage

// File: rtl/pcie_us_msix_arb_if.sv
// MSI-X table read port plus the UltraScale+ cfg_interrupt_msix_* request port.
//   master : arbiter side (drives table strobe/index and message/int)
//   slave  : table + PCIe core side (returns vector contents, enable/mask, sent/fail)
interface pcie_us_msix_arb_if #(
  parameter int unsigned IRQ_INDEX_WIDTH = 5
) ();
  import pcie_us_msix_pkg::*;

  logic                       tbl_rd_en;
  logic [IRQ_INDEX_WIDTH-1:0] tbl_rd_index;
  logic [MSIX_ADDR_WIDTH-1:0] tbl_rd_addr;
  logic [MSIX_DATA_WIDTH-1:0] tbl_rd_data;
  logic                       tbl_rd_mask;

  logic                       cfg_interrupt_msix_enable;
  logic                       cfg_interrupt_msix_mask;
  logic [MSIX_ADDR_WIDTH-1:0] cfg_interrupt_msix_address;
  logic [MSIX_DATA_WIDTH-1:0] cfg_interrupt_msix_data;
  logic                       cfg_interrupt_msix_int;
  logic                       cfg_interrupt_msix_sent;
  logic                       cfg_interrupt_msix_fail;

  modport master (
    output tbl_rd_en, tbl_rd_index,
    input  tbl_rd_addr, tbl_rd_data, tbl_rd_mask,
    input  cfg_interrupt_msix_enable, cfg_interrupt_msix_mask,
    output cfg_interrupt_msix_address, cfg_interrupt_msix_data, cfg_interrupt_msix_int,
    input  cfg_interrupt_msix_sent, cfg_interrupt_msix_fail
  );

  modport slave (
    input  tbl_rd_en, tbl_rd_index,
    output tbl_rd_addr, tbl_rd_data, tbl_rd_mask,
    output cfg_interrupt_msix_enable, cfg_interrupt_msix_mask,
    input  cfg_interrupt_msix_address, cfg_interrupt_msix_data, cfg_interrupt_msix_int,
    output cfg_interrupt_msix_sent, cfg_interrupt_msix_fail
  );

endinterface

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder (purely combinational).
//   req   : request vector
//   valid : any request bit set
//   idx   : index of the lowest set bit (0 when none)
module priority_encoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the last hit (lowest index) wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pcie_us_msix_arb.sv
// Round-robin arbiter of IRQ_COUNT interrupt sources onto the PCIe MSI-X request port (PF0).
//   clk, rst       : user clock, synchronous active-high reset
//   irq_req        : per-source event pulses, latched into pending bits
//   msix           : table read port + cfg_interrupt_msix_* (master view)
//   status_pending : pending bits
//   status_busy    : FSM not idle
//   status_fail    : one-cycle pulse on core fail or response timeout
module pcie_us_msix_arb
  import pcie_us_msix_pkg::*;
#(
  parameter int unsigned IRQ_COUNT       = 32,
  parameter int unsigned IRQ_INDEX_WIDTH = $clog2(IRQ_COUNT),
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IRQ_COUNT-1:0]  irq_req,
  pcie_us_msix_arb_if.master    msix,
  output logic [IRQ_COUNT-1:0]  status_pending,
  output logic                  status_busy,
  output logic                  status_fail
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_t                     state;
  logic [IRQ_COUNT-1:0]       pending_q;
  logic [IRQ_INDEX_WIDTH-1:0] rr_ptr;
  logic [IRQ_INDEX_WIDTH-1:0] grant_q;
  logic [CNT_W-1:0]           timeout_cnt;
  msix_msg_t                  msg_q;
  logic                       rd_en_q;
  logic                       int_q;
  logic                       busy_q;
  logic                       fail_q;

  logic [IRQ_COUNT-1:0]       pending_next_c;
  logic [IRQ_COUNT-1:0]       rr_mask_c;
  logic [IRQ_COUNT-1:0]       pend_masked_c;
  logic                       masked_valid_c;
  logic                       full_valid_c;
  logic [IRQ_INDEX_WIDTH-1:0] masked_idx_c;
  logic [IRQ_INDEX_WIDTH-1:0] full_idx_c;
  logic [IRQ_INDEX_WIDTH-1:0] sel_idx_c;
  logic [IRQ_INDEX_WIDTH-1:0] rr_next_c;
  logic                       func_ok_c;

  // Only sources at or above rr_ptr compete first; fall back to the full set on wrap.
  assign rr_mask_c     = {IRQ_COUNT{1'b1}} << rr_ptr;
  assign pend_masked_c = pending_q & rr_mask_c;

  priority_encoder #(
    .WIDTH (IRQ_COUNT),
    .IDX_W (IRQ_INDEX_WIDTH)
  ) u_pe_masked (
    .req   (pend_masked_c),
    .valid (masked_valid_c),
    .idx   (masked_idx_c)
  );

  priority_encoder #(
    .WIDTH (IRQ_COUNT),
    .IDX_W (IRQ_INDEX_WIDTH)
  ) u_pe_full (
    .req   (pending_q),
    .valid (full_valid_c),
    .idx   (full_idx_c)
  );

  assign sel_idx_c = masked_valid_c ? masked_idx_c : full_idx_c;
  assign rr_next_c = (grant_q == IRQ_INDEX_WIDTH'(IRQ_COUNT - 1))
                   ? '0 : grant_q + IRQ_INDEX_WIDTH'(1);
  assign func_ok_c = msix.cfg_interrupt_msix_enable && !msix.cfg_interrupt_msix_mask;

  // Clear on a clean sent (fail wins over sent), then OR in new events so set wins.
  always_comb begin
    pending_next_c = pending_q;
    if (state == ST_WAIT && msix.cfg_interrupt_msix_sent && !msix.cfg_interrupt_msix_fail) begin
      pending_next_c[grant_q] = 1'b0;
    end
    pending_next_c = pending_next_c | irq_req;
  end

  // Attempt sequencer: IDLE -> LOOKUP -> CHECK -> (IDLE | ISSUE -> WAIT -> IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending_q   <= '0;
      rr_ptr      <= '0;
      grant_q     <= '0;
      timeout_cnt <= '0;
      msg_q       <= '0;
      rd_en_q     <= 1'b0;
      int_q       <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      rd_en_q   <= 1'b0;
      int_q     <= 1'b0;
      fail_q    <= 1'b0;
      pending_q <= pending_next_c;

      case (state)
        ST_IDLE: begin
          if (func_ok_c && full_valid_c) begin
            grant_q <= sel_idx_c;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          state <= ST_CHECK;
        end

        // Table data is valid this cycle; message regs then hold until WAIT exits.
        ST_CHECK: begin
          msg_q.addr <= msix.tbl_rd_addr;
          msg_q.data <= msix.tbl_rd_data;
          if (msix.tbl_rd_mask || !func_ok_c) begin
            rr_ptr <= rr_next_c;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            int_q <= 1'b1;
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          timeout_cnt <= '0;
          state       <= ST_WAIT;
        end

        // Exit on sent, fail or timeout; anything other than a clean sent reports failure.
        ST_WAIT: begin
          if (msix.cfg_interrupt_msix_sent || msix.cfg_interrupt_msix_fail ||
              timeout_cnt == CNT_W'(TIMEOUT - 1)) begin
            fail_q <= msix.cfg_interrupt_msix_fail || !msix.cfg_interrupt_msix_sent;
            rr_ptr <= rr_next_c;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign msix.tbl_rd_en                  = rd_en_q;
  assign msix.tbl_rd_index               = grant_q;
  assign msix.cfg_interrupt_msix_address = msg_q.addr;
  assign msix.cfg_interrupt_msix_data    = msg_q.data;
  assign msix.cfg_interrupt_msix_int     = int_q;
  assign status_pending                  = pending_q;
  assign status_busy                     = busy_q;
  assign status_fail                     = fail_q;

endmodule

// File: tb/tb_pcie_us_msix_arb.sv
// Directed self-checking bench for pcie_us_msix_arb (32 sources, TIMEOUT 1024).
`timescale 1ns/1ps
module tb_pcie_us_msix_arb;

  logic        clk;
  logic        rst;
  logic [31:0] irq_req;
  logic [31:0] status_pending;
  logic        status_busy;
  logic        status_fail;

  pcie_us_msix_arb_if #(.IRQ_INDEX_WIDTH(5)) msix_if ();

  pcie_us_msix_arb #(
    .IRQ_COUNT       (32),
    .IRQ_INDEX_WIDTH (5),
    .TIMEOUT         (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_req        (irq_req),
    .msix           (msix_if),
    .status_pending (status_pending),
    .status_busy    (status_busy),
    .status_fail    (status_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // MSI-X table contents
  logic [63:0] tbl_addr [32];
  logic [31:0] tbl_data [32];
  logic        tbl_mask [32];

  // Table model: one-cycle read latency
  always @(posedge clk) begin
    if (msix_if.tbl_rd_en === 1'b1) begin
      msix_if.tbl_rd_addr <= tbl_addr[msix_if.tbl_rd_index];
      msix_if.tbl_rd_data <= tbl_data[msix_if.tbl_rd_index];
      msix_if.tbl_rd_mask <= tbl_mask[msix_if.tbl_rd_index];
    end
  end

  // Core model: mode 0 = sent, 1 = fail, 2 = silent; response resp_delay+1 cycles after the int cycle
  int resp_mode  = 0;
  int resp_delay = 0;
  bit armed      = 1'b0;
  int resp_cnt   = 0;
  always @(posedge clk) begin
    msix_if.cfg_interrupt_msix_sent <= 1'b0;
    msix_if.cfg_interrupt_msix_fail <= 1'b0;
    if (msix_if.cfg_interrupt_msix_int === 1'b1 && resp_mode != 2) begin
      armed    <= 1'b1;
      resp_cnt <= resp_delay;
    end else if (armed) begin
      if (resp_cnt == 0) begin
        armed <= 1'b0;
        if (resp_mode == 0) msix_if.cfg_interrupt_msix_sent <= 1'b1;
        else                msix_if.cfg_interrupt_msix_fail <= 1'b1;
      end else begin
        resp_cnt <= resp_cnt - 1;
      end
    end
  end

  // Observers
  logic [31:0] strobe_data_q[$];
  logic [63:0] strobe_addr_q[$];
  int rd_cnt   = 0;
  int fail_cnt = 0;
  always @(posedge clk) begin
    if (msix_if.cfg_interrupt_msix_int === 1'b1) begin
      strobe_data_q.push_back(msix_if.cfg_interrupt_msix_data);
      strobe_addr_q.push_back(msix_if.cfg_interrupt_msix_address);
    end
    if (msix_if.tbl_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
    if (status_fail === 1'b1) fail_cnt <= fail_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // irq_req high for exactly one cycle (cycle N); returns at cycle N+1
  task automatic pulse_irq(input logic [31:0] v);
    irq_req = v;
    tick(1);
    irq_req = '0;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    irq_req = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_clear(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (status_pending == 32'h0 && status_busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    irq_req = '0;
    msix_if.cfg_interrupt_msix_enable = 1'b1;
    msix_if.cfg_interrupt_msix_mask   = 1'b0;
    tick(3);
    tests_run++; if (status_pending !== 32'h0) begin tests_failed++; $display("FAIL reset_pending: got %h expected 0", status_pending); end
    tests_run++; if (status_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", status_busy); end
    tests_run++; if (msix_if.tbl_rd_en !== 1'b0 || msix_if.cfg_interrupt_msix_int !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got rd_en=%b int=%b expected 0/0", msix_if.tbl_rd_en, msix_if.cfg_interrupt_msix_int); end
    tests_run++; if (msix_if.cfg_interrupt_msix_address !== 64'h0 || msix_if.cfg_interrupt_msix_data !== 32'h0) begin tests_failed++; $display("FAIL reset_msg: got %h/%h expected 0/0", msix_if.cfg_interrupt_msix_address, msix_if.cfg_interrupt_msix_data); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    pulse_irq(32'h0000_0020);
    tests_run++; if (status_pending !== 32'h0000_0020 || msix_if.tbl_rd_en !== 1'b0) begin tests_failed++; $display("FAIL single_n1: got pend=%h rd_en=%b expected 00000020/0", status_pending, msix_if.tbl_rd_en); end
    tick(1);
    tests_run++; if (msix_if.tbl_rd_en !== 1'b1 || msix_if.tbl_rd_index !== 5'd5 || status_busy !== 1'b1) begin tests_failed++; $display("FAIL single_lookup: got rd_en=%b idx=%0d busy=%b expected 1/5/1", msix_if.tbl_rd_en, msix_if.tbl_rd_index, status_busy); end
    tick(1);
    tests_run++; if (msix_if.tbl_rd_en !== 1'b0 || msix_if.cfg_interrupt_msix_int !== 1'b0) begin tests_failed++; $display("FAIL single_check: got rd_en=%b int=%b expected 0/0", msix_if.tbl_rd_en, msix_if.cfg_interrupt_msix_int); end
    tick(1);
    tests_run++; if (msix_if.cfg_interrupt_msix_int !== 1'b1 || msix_if.cfg_interrupt_msix_address !== 64'h0000_0000_FEE0_0000 || msix_if.cfg_interrupt_msix_data !== 32'h25) begin tests_failed++; $display("FAIL single_issue: got int=%b addr=%h data=%h expected 1/00000000fee00000/00000025", msix_if.cfg_interrupt_msix_int, msix_if.cfg_interrupt_msix_address, msix_if.cfg_interrupt_msix_data); end
    tick(1);
    tests_run++; if (msix_if.cfg_interrupt_msix_int !== 1'b0 || msix_if.cfg_interrupt_msix_data !== 32'h25) begin tests_failed++; $display("FAIL single_wait_hold: got int=%b data=%h expected 0/00000025", msix_if.cfg_interrupt_msix_int, msix_if.cfg_interrupt_msix_data); end
    tick(1);
    tests_run++; if (status_pending !== 32'h0000_0020) begin tests_failed++; $display("FAIL single_pend_before_sent: got %h expected 00000020", status_pending); end
    tick(1);
    tests_run++; if (status_pending !== 32'h0 || status_busy !== 1'b0) begin tests_failed++; $display("FAIL single_done: got pend=%h busy=%b expected 0/0", status_pending, status_busy); end
    wait_clear(5, ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    apply_reset();
    base = strobe_data_q.size();
    pulse_irq(32'h8000_0088);
    wait_clear(100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_drain1: got pend=%h expected 0 within 100 cycles", status_pending); end
    tests_run++; if (strobe_data_q.size() !== base + 3) begin tests_failed++; $display("FAIL rr_count1: got %0d expected %0d", strobe_data_q.size() - base, 3); end
    else begin
      tests_run++; if (strobe_data_q[base] !== 32'h23 || strobe_data_q[base+1] !== 32'h27 || strobe_data_q[base+2] !== 32'h3F) begin tests_failed++; $display("FAIL rr_order1: got %h,%h,%h expected 23,27,3f", strobe_data_q[base], strobe_data_q[base+1], strobe_data_q[base+2]); end
      tests_run++; if (strobe_addr_q[base+2] !== 64'h0000_001F_FEE0_0000) begin tests_failed++; $display("FAIL rr_addr31: got %h expected 0000001ffee00000", strobe_addr_q[base+2]); end
    end
    base = strobe_data_q.size();
    pulse_irq(32'h0000_0009);
    wait_clear(100, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2) begin tests_failed++; $display("FAIL rr_drain2: got ok=%b count=%0d expected 1/2", ok, strobe_data_q.size() - base); end
    else begin
      tests_run++; if (strobe_data_q[base] !== 32'h20 || strobe_data_q[base+1] !== 32'h23) begin tests_failed++; $display("FAIL rr_wrap_order: got %h,%h expected 20,23", strobe_data_q[base], strobe_data_q[base+1]); end
    end
  endtask

  task automatic test_masked();
    bit ok;
    int base, rbase;
    apply_reset();
    tbl_mask[2] = 1'b1;
    base  = strobe_data_q.size();
    rbase = rd_cnt;
    pulse_irq(32'h0000_0014);
    tick(40);
    tests_run++; if (strobe_data_q.size() !== base + 1) begin tests_failed++; $display("FAIL masked_count: got %0d expected 1", strobe_data_q.size() - base); end
    else begin
      tests_run++; if (strobe_data_q[base] !== 32'h24) begin tests_failed++; $display("FAIL masked_other: got %h expected 24", strobe_data_q[base]); end
    end
    tests_run++; if (status_pending !== 32'h0000_0004) begin tests_failed++; $display("FAIL masked_pending: got %h expected 00000004", status_pending); end
    tests_run++; if (rd_cnt - rbase < 3) begin tests_failed++; $display("FAIL masked_relookup: got %0d reads expected >=3", rd_cnt - rbase); end
    tbl_mask[2] = 1'b0;
    wait_clear(50, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2 || strobe_data_q[strobe_data_q.size()-1] !== 32'h22) begin tests_failed++; $display("FAIL masked_unmask: got ok=%b count=%0d expected 1/2 with data 22", ok, strobe_data_q.size() - base); end
  endtask

  task automatic test_fail();
    bit ok;
    int base, fbase;
    apply_reset();
    resp_mode = 1;
    base  = strobe_data_q.size();
    fbase = fail_cnt;
    pulse_irq(32'h0000_0002);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (fail_cnt > fbase) begin ok = 1'b1; break; end
    end
    resp_mode = 0;
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL fail_pulse: got no status_fail expected pulse within 30 cycles"); end
    tests_run++; if (status_pending !== 32'h0000_0002) begin tests_failed++; $display("FAIL fail_keep_pending: got %h expected 00000002", status_pending); end
    wait_clear(50, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2) begin tests_failed++; $display("FAIL fail_reissue: got ok=%b count=%0d expected 1/2", ok, strobe_data_q.size() - base); end
    tests_run++; if (fail_cnt - fbase !== 1) begin tests_failed++; $display("FAIL fail_pulse_width: got %0d expected 1", fail_cnt - fbase); end
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    apply_reset();
    resp_mode = 2;
    base = strobe_data_q.size();
    pulse_irq(32'h0000_0100);
    tick(1027);
    tests_run++; if (status_busy !== 1'b1 || status_fail !== 1'b0) begin tests_failed++; $display("FAIL timeout_last_wait: got busy=%b fail=%b expected 1/0", status_busy, status_fail); end
    tick(1);
    tests_run++; if (status_fail !== 1'b1 || status_busy !== 1'b0 || status_pending !== 32'h0000_0100) begin tests_failed++; $display("FAIL timeout_expire: got fail=%b busy=%b pend=%h expected 1/0/00000100", status_fail, status_busy, status_pending); end
    resp_mode = 0;
    wait_clear(50, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2) begin tests_failed++; $display("FAIL timeout_retry: got ok=%b count=%0d expected 1/2", ok, strobe_data_q.size() - base); end
  endtask

  task automatic test_gating();
    bit ok;
    int base, rbase;
    apply_reset();
    msix_if.cfg_interrupt_msix_enable = 1'b0;
    rbase = rd_cnt;
    base  = strobe_data_q.size();
    pulse_irq(32'h0000_0200);
    tick(10);
    tests_run++; if (rd_cnt !== rbase || status_pending !== 32'h0000_0200) begin tests_failed++; $display("FAIL gate_disabled: got reads=%0d pend=%h expected 0/00000200", rd_cnt - rbase, status_pending); end
    msix_if.cfg_interrupt_msix_enable = 1'b1;
    tick(1);
    tests_run++; if (msix_if.tbl_rd_en !== 1'b1 || msix_if.tbl_rd_index !== 5'd9) begin tests_failed++; $display("FAIL gate_lookup: got rd_en=%b idx=%0d expected 1/9", msix_if.tbl_rd_en, msix_if.tbl_rd_index); end
    tick(2);
    tests_run++; if (msix_if.cfg_interrupt_msix_int !== 1'b1 || msix_if.cfg_interrupt_msix_data !== 32'h29) begin tests_failed++; $display("FAIL gate_issue: got int=%b data=%h expected 1/00000029", msix_if.cfg_interrupt_msix_int, msix_if.cfg_interrupt_msix_data); end
    wait_clear(20, ok);
    msix_if.cfg_interrupt_msix_mask = 1'b1;
    rbase = rd_cnt;
    pulse_irq(32'h0000_0400);
    tick(10);
    tests_run++; if (rd_cnt !== rbase || status_pending !== 32'h0000_0400) begin tests_failed++; $display("FAIL gate_fmask: got reads=%0d pend=%h expected 0/00000400", rd_cnt - rbase, status_pending); end
    msix_if.cfg_interrupt_msix_mask = 1'b0;
    wait_clear(20, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2 || strobe_data_q[strobe_data_q.size()-1] !== 32'h2A) begin tests_failed++; $display("FAIL gate_unmask: got ok=%b count=%0d expected 1/2 with data 2a", ok, strobe_data_q.size() - base); end
  endtask

  task automatic test_collision();
    bit ok;
    int base;
    apply_reset();
    base = strobe_data_q.size();
    pulse_irq(32'h0000_0040);
    tick(5);
    tests_run++; if (msix_if.cfg_interrupt_msix_sent !== 1'b1) begin tests_failed++; $display("FAIL coll_sent_cycle: got sent=%b expected 1", msix_if.cfg_interrupt_msix_sent); end
    irq_req = 32'h0000_0040;
    tick(1);
    irq_req = '0;
    tests_run++; if (status_pending !== 32'h0000_0040 || status_busy !== 1'b0) begin tests_failed++; $display("FAIL coll_set_wins: got pend=%h busy=%b expected 00000040/0", status_pending, status_busy); end
    wait_clear(30, ok);
    tests_run++; if (!ok || strobe_data_q.size() !== base + 2 || strobe_data_q[base+1] !== 32'h26) begin tests_failed++; $display("FAIL coll_redeliver: got ok=%b count=%0d expected 1/2 with data 26", ok, strobe_data_q.size() - base); end
  endtask

  task automatic test_reset_mid();
    int base, fbase;
    apply_reset();
    resp_delay = 5;
    base  = strobe_data_q.size();
    fbase = fail_cnt;
    pulse_irq(32'h0000_0800);
    tick(5);
    tests_run++; if (status_busy !== 1'b1 || strobe_data_q.size() !== base + 1) begin tests_failed++; $display("FAIL rstmid_in_wait: got busy=%b count=%0d expected 1/1", status_busy, strobe_data_q.size() - base); end
    rst = 1'b1;
    tick(1);
    tests_run++; if (status_pending !== 32'h0 || status_busy !== 1'b0 || status_fail !== 1'b0) begin tests_failed++; $display("FAIL rstmid_status: got pend=%h busy=%b fail=%b expected 0/0/0", status_pending, status_busy, status_fail); end
    tests_run++; if (msix_if.tbl_rd_en !== 1'b0 || msix_if.tbl_rd_index !== 5'd0 || msix_if.cfg_interrupt_msix_int !== 1'b0 || msix_if.cfg_interrupt_msix_address !== 64'h0 || msix_if.cfg_interrupt_msix_data !== 32'h0) begin tests_failed++; $display("FAIL rstmid_outputs: got rd_en=%b idx=%0d int=%b addr=%h data=%h expected all 0", msix_if.tbl_rd_en, msix_if.tbl_rd_index, msix_if.cfg_interrupt_msix_int, msix_if.cfg_interrupt_msix_address, msix_if.cfg_interrupt_msix_data); end
    rst = 1'b0;
    tick(6);
    tests_run++; if (status_pending !== 32'h0 || status_busy !== 1'b0 || strobe_data_q.size() !== base + 1 || fail_cnt !== fbase) begin tests_failed++; $display("FAIL rstmid_late_sent: got pend=%h busy=%b strobes=%0d fails=%0d expected 0/0/1/0", status_pending, status_busy, strobe_data_q.size() - base, fail_cnt - fbase); end
    resp_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_addr[i] = {32'(i), 32'hFEE0_0000};
      tbl_data[i] = 32'h20 + 32'(i);
      tbl_mask[i] = 1'b0;
    end
    tbl_addr[5] = 64'h0000_0000_FEE0_0000;
    rst     = 1'b1;
    irq_req = '0;
    msix_if.cfg_interrupt_msix_enable = 1'b1;
    msix_if.cfg_interrupt_msix_mask   = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_masked();
    test_fail();
    test_timeout();
    test_gating();
    test_collision();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
